// File: rtl/mul_pkg.sv
// Shared multiplier definitions: op encoding, product/result widths and word-select helpers.
package mul_pkg;

  localparam int PROD_W = 65;
  localparam int RES_W  = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_e;

  // MUL returns the low word; every MULH* flavour returns the high word.
  function automatic logic [RES_W-1:0] mul_sel_word(input mul_op_e op, input logic [63:0] r);
    return (op == MUL_OP_MUL) ? r[31:0] : r[63:32];
  endfunction

  // Signed low-word result does not fit when the high word is not a sign extension of it.
  function automatic logic mul_lo_ovf(input mul_op_e op, input logic [63:0] r);
    return (op == MUL_OP_MUL) && (r[63:32] != {32{r[31]}});
  endfunction

endpackage

// File: rtl/mul_rq_fifo.sv
// Generic in-order FIFO with circular pointers (wrap modulo N) and an occupancy counter.
module mul_rq_fifo #(
  parameter int W  = 32,
  parameter int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [N-1:0][W-1:0] mem_q;
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is reset too so the head reads zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_i) rptr_q <= ptr_inc(rptr_q);
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(N));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mul_result_queue.sv
// Multiplier back end: sign correction register, word select, in-order result FIFO to writeback.
// Optional MUL_RQ_OVF_EN adds a per-result low-word signed overflow flag (out_ovf).
module mul_result_queue
  import mul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_neg,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef MUL_RQ_OVF_EN
  ,
  output logic              out_ovf
`endif
);

  localparam int FN = DEPTH - 1;
  localparam int CW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
`ifdef MUL_RQ_OVF_EN
  localparam int EW = RES_W + TAG_W + 1;
`else
  localparam int EW = RES_W + TAG_W;
`endif

  logic             s1_valid_q, s1_valid_d;
  logic [63:0]      s1_r_q, s1_r_d;
  mul_op_e          s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic [EW-1:0]    fifo_din, fifo_dout;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic             accept, pop, s1_drain;
  logic [OW-1:0]    occ;
  logic [63:0]      mag;
  logic [RES_W-1:0] s1_word;
  logic             unused_prod_msb;

  assign unused_prod_msb = in_prod[PROD_W-1];
  assign mag             = in_prod[63:0];

  // Only registered occupancy feeds in_ready, so out_ready never reaches it.
  assign occ      = OW'(fifo_cnt) + OW'(s1_valid_q);
  assign in_ready = (occ < OW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop      = out_valid && out_ready;
  // S1 only stalls when the FIFO is full and nothing leaves; in_ready is low then.
  assign s1_drain = s1_valid_q && (!fifo_full || pop);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_r_d     = s1_r_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (s1_drain) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_r_d     = in_neg ? (~mag + 64'd1) : mag;
      s1_op_d    = mul_op_e'(in_op);
      s1_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_op_q    <= MUL_OP_MUL;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_r_q     <= s1_r_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  assign s1_word = mul_sel_word(s1_op_q, s1_r_q);

`ifdef MUL_RQ_OVF_EN
  assign fifo_din = {s1_word, s1_tag_q, mul_lo_ovf(s1_op_q, s1_r_q)};
  assign {out_data, out_tag, out_ovf} = fifo_dout;
`else
  assign fifo_din = {s1_word, s1_tag_q};
  assign {out_data, out_tag} = fifo_dout;
`endif

  mul_rq_fifo #(
    .W (EW),
    .N (FN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s1_drain),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_mul_result_queue.sv
// Directed self-checking bench for mul_result_queue (DEPTH=4, TAG_W=5).
module tb_mul_result_queue;

  logic        clk, rst;
  logic        in_valid, in_ready, in_neg;
  logic [64:0] in_prod;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
`ifdef MUL_RQ_OVF_EN
  logic        out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  mul_result_queue #(.DEPTH(4), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_neg    (in_neg),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef MUL_RQ_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_neg = 1'b0; in_op = 2'd0; in_tag = '0;
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag: got %h exp 0", out_tag); end
`ifdef MUL_RQ_OVF_EN
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b exp 0", out_ovf); end
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    in_valid = 1'b1; in_prod = 65'h6; in_neg = 1'b0; in_op = 2'd0; in_tag = 5'd3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b exp 1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_n1: got %b exp 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_n2: got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h6) begin errors++; $display("FAIL basic_data: got %h exp 00000006", out_data); end
    checks++; if (out_tag !== 5'd3) begin errors++; $display("FAIL basic_tag: got %0d exp 3", out_tag); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b exp 0", out_valid); end
  endtask

  task automatic test_sign_word;
    logic [64:0] prod [6];
    logic        neg  [6];
    logic [1:0]  op   [6];
    logic [31:0] exp  [6];
    prod[0] = 65'h6;                      neg[0] = 1; op[0] = 0; exp[0] = 32'hFFFFFFFA;
    prod[1] = 65'h6;                      neg[1] = 1; op[1] = 1; exp[1] = 32'hFFFFFFFF;
    prod[2] = 65'h0;                      neg[2] = 1; op[2] = 1; exp[2] = 32'h00000000;
    prod[3] = 65'h0_FFFFFFFE_00000001;    neg[3] = 0; op[3] = 3; exp[3] = 32'hFFFFFFFE;
    prod[4] = 65'h0_FFFFFFFE_00000001;    neg[4] = 1; op[4] = 2; exp[4] = 32'h00000001;
    prod[5] = 65'h1_00000000_00000005;    neg[5] = 0; op[5] = 0; exp[5] = 32'h00000005;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_prod = prod[i]; in_neg = neg[i]; in_op = op[i]; in_tag = 5'(i + 1);
      tick;
      in_valid = 1'b0;
      tick;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sign_valid[%0d]: got %b exp 1", i, out_valid); end
      checks++; if (out_data !== exp[i]) begin errors++; $display("FAIL sign_data[%0d]: got %h exp %h", i, out_data, exp[i]); end
      checks++; if (out_tag !== 5'(i + 1)) begin errors++; $display("FAIL sign_tag[%0d]: got %0d exp %0d", i, out_tag, i + 1); end
      tick;
    end
  endtask

  task automatic test_backpressure;
    int  acc;
    logic took, got5;
    acc = 0; got5 = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_neg = 1'b0; in_op = 2'd0;
    for (int i = 0; i < 8; i++) begin
      in_tag = 5'(10 + acc); in_prod = 65'(10 + acc);
      took = in_ready;
      tick;
      if (took) acc++;
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d exp 4", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b exp 0", in_ready); end
    checks++; if (out_tag !== 5'd10) begin errors++; $display("FAIL bp_head_stable: got %0d exp 10", out_tag); end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_tag !== 5'(10 + k) || out_data !== 32'(10 + k)) begin
        errors++; $display("FAIL bp_drain[%0d]: got v=%b tag=%0d data=%h exp v=1 tag=%0d", k, out_valid, out_tag, out_data, 10 + k);
      end
      took = in_valid && in_ready;
      tick;
      if (took) begin in_valid = 1'b0; got5 = 1'b1; end
    end
    checks++; if (got5 !== 1'b1) begin errors++; $display("FAIL bp_fifth_accepted: got %b exp 1", got5); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_after: got %b exp 0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    int   nxt;
    logic took;
    nxt = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_neg = 1'b0; in_op = 2'd0;
    for (int i = 0; i < 8; i++) begin
      in_tag = 5'(nxt); in_prod = 65'(32'h100 + nxt);
      took = in_ready;
      tick;
      if (took) nxt++;
    end
    in_tag = 5'(nxt); in_prod = 65'(32'h100 + nxt);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checks++; if (out_valid !== 1'b1 || out_tag !== 5'(k) || out_data !== 32'(32'h100 + k)) begin
        errors++; $display("FAIL stream[%0d]: got v=%b tag=%0d data=%h exp v=1 tag=%0d", k, out_valid, out_tag, out_data, k);
      end
      took = in_valid && in_ready;
      tick;
      if (took) begin
        nxt++;
        if (nxt == 20) in_valid = 1'b0;
        else begin in_tag = 5'(nxt); in_prod = 65'(32'h100 + nxt); end
      end
    end
    checks++; if (nxt !== 20) begin errors++; $display("FAIL stream_all_sent: got %0d exp 20", nxt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_no_dup: got %b exp 0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    int   acc;
    logic took;
    acc = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_neg = 1'b0; in_op = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_tag = 5'(20 + i); in_prod = 65'(20 + i);
      took = in_ready;
      tick;
      if (took) acc++;
    end
    in_valid = 1'b0;
    checks++; if (acc !== 4 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_prefill: got acc=%0d v=%b exp acc=4 v=1", acc, out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b exp 1", in_ready); end
    checks++; if (out_data !== 32'h0 || out_tag !== 5'h0) begin errors++; $display("FAIL rst_mid_outputs: got data=%h tag=%0d exp 0", out_data, out_tag); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_prod = 65'h55; in_tag = 5'd7;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_after_n1: got %b exp 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1 || out_tag !== 5'd7 || out_data !== 32'h55) begin
      errors++; $display("FAIL rst_after_n2: got v=%b tag=%0d data=%h exp v=1 tag=7 data=00000055", out_valid, out_tag, out_data);
    end
    tick;
  endtask

`ifdef MUL_RQ_OVF_EN
  task automatic test_ovf;
    logic [64:0] prod [4];
    logic        neg  [4];
    logic [1:0]  op   [4];
    logic        exp  [4];
    prod[0] = 65'h1_00000000; neg[0] = 0; op[0] = 0; exp[0] = 1;
    prod[1] = 65'h7FFFFFFF;   neg[1] = 0; op[1] = 0; exp[1] = 0;
    prod[2] = 65'h1_00000000; neg[2] = 0; op[2] = 3; exp[2] = 0;
    prod[3] = 65'h6;          neg[3] = 1; op[3] = 0; exp[3] = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_prod = prod[i]; in_neg = neg[i]; in_op = op[i]; in_tag = 5'(i);
      tick;
      in_valid = 1'b0;
      tick;
      checks++; if (out_valid !== 1'b1 || out_ovf !== exp[i]) begin
        errors++; $display("FAIL ovf[%0d]: got v=%b ovf=%b exp v=1 ovf=%b", i, out_valid, out_ovf, exp[i]);
      end
      tick;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_sign_word;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
`ifdef MUL_RQ_OVF_EN
    test_ovf;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
